memory_responder_module: RTL and testbench

//  Responder end of the controller->memory command interface. Accepts 3-bit MS commands

---
 rtl/memory_responder_module.sv | 154 +++++++++++++++
 tb/tb_memory_responder_module.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/memory_responder_module.sv
// Responder side of the controller->memory command link: executes WRITE/READ/CLEAR/INC
// on a small register file. Optional MEMRESP_RESET_CLEAR_EN makes reset also zero memory.
module memory_responder_module #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        MS,
  input  logic              cmd_valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              cmd_ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [2:0] MS_NOP   = 3'b000;
  localparam logic [2:0] MS_WRITE = 3'b001;
  localparam logic [2:0] MS_READ  = 3'b010;
  localparam logic [2:0] MS_CLEAR = 3'b011;
  localparam logic [2:0] MS_INC   = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_CLR,
    S_INC_RD,
    S_INC_WR,
    S_DONE
  } state_t;

  state_t              state;
  state_t              next_state;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   word_q;
  logic [ADDR_W-1:0]   idx;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                accept;
  logic                legal;
  logic [DATA_W-1:0]   inc_word;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  assign accept   = cmd_valid && (state == S_IDLE) && (MS != MS_NOP);
  assign legal    = (MS == MS_WRITE) || (MS == MS_READ) || (MS == MS_CLEAR) || (MS == MS_INC);
  assign inc_word = word_q + {{(DATA_W-1){1'b0}}, 1'b1};

  assign cmd_ready = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign err       = (state == S_DONE) && err_q;
  assign rdata     = rdata_q;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (MS)
            MS_WRITE: next_state = S_WR;
            MS_READ:  next_state = S_RD;
            MS_CLEAR: next_state = S_CLR;
            MS_INC:   next_state = S_INC_RD;
            default:  next_state = S_DONE;
          endcase
        end
      end
      S_WR:     next_state = S_DONE;
      S_RD:     next_state = S_DONE;
      S_CLR:    if (idx == {ADDR_W{1'b1}}) next_state = S_DONE;
      S_INC_RD: next_state = S_INC_WR;
      S_INC_WR: next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Single write port: at most one of WR / CLR / INC_WR is active in any cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = wdata_q;
    case (state)
      S_WR: begin
        mem_we = 1'b1;
      end
      S_CLR: begin
        mem_we    = 1'b1;
        mem_waddr = idx;
        mem_wdata = '0;
      end
      S_INC_WR: begin
        mem_we    = 1'b1;
        mem_wdata = inc_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      err_q   <= 1'b0;
      rdata_q <= '0;
      idx     <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        err_q <= !legal;
        idx   <= '0;
      end
      if (state == S_CLR)    idx     <= idx + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (state == S_RD)     rdata_q <= mem[addr_q];
      if (state == S_INC_WR) rdata_q <= inc_word;
    end
  end

  // Command operands and the INC scratch word carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= addr;
      wdata_q <= wdata;
    end
    if (state == S_INC_RD) word_q <= mem[addr_q];
  end

  // A write in flight at a reset edge still lands, so an aborted CLEAR stays partial.
`ifdef MEMRESP_RESET_CLEAR_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end
`endif

endmodule

// File: tb/tb_memory_responder_module.sv
// Directed self-checking bench for memory_responder_module.
module tb_memory_responder_module;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] ms = 3'b000;
  logic       cmd_valid = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] wdata = 8'h00;
  logic       cmd_ready;
  logic       done;
  logic       err;
  logic [7:0] rdata;

  int checks = 0;
  int errors = 0;

  memory_responder_module #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .MS        (ms),
    .cmd_valid (cmd_valid),
    .addr      (addr),
    .wdata     (wdata),
    .cmd_ready (cmd_ready),
    .done      (done),
    .err       (err),
    .rdata     (rdata)
  );

  always #5 clk = ~clk;

  // Present a command for one cycle; returns in cycle T+1 (1ns after the accept edge).
  task automatic send(input logic [2:0] m, input logic [2:0] a, input logic [7:0] d);
    ms = m; addr = a; wdata = d; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; ms = 3'b000;
  endtask

  // Latency counted from the accept cycle; leaves the DUT back in IDLE.
  task automatic wait_done(output int lat, output logic e, output logic [7:0] r);
    lat = 0; e = 1'bx; r = 8'hxx;
    for (int n = 1; n <= 20; n++) begin
      if (done === 1'b1) begin
        lat = n; e = err; r = rdata;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within 20 cycles");
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_cmd(input logic [2:0] m, input logic [2:0] a, input logic [7:0] d,
                        output int lat, output logic e, output logic [7:0] r);
    send(m, a, d);
    wait_done(lat, e, r);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    int lat; logic e; logic [7:0] r;
    send(3'b001, 3'd3, 8'hA5);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_busy_ready: got %b want 0", cmd_ready); end
    wait_done(lat, e, r);
    checks++; if (lat != 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", lat); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", e); end
    do_cmd(3'b010, 3'd3, 8'h00, lat, e, r);
    checks++; if (lat != 2) begin errors++; $display("FAIL rd_latency: got %0d want 2", lat); end
    checks++; if (r !== 8'hA5) begin errors++; $display("FAIL rd_data: got %h want a5", r); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", e); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rd_idle_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_inc;
    int lat; logic e; logic [7:0] r;
    do_cmd(3'b001, 3'd5, 8'hFF, lat, e, r);
    do_cmd(3'b100, 3'd5, 8'h00, lat, e, r);
    checks++; if (lat != 3) begin errors++; $display("FAIL inc_latency: got %0d want 3", lat); end
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL inc_wrap_rdata: got %h want 00", r); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL inc_err: got %b want 0", e); end
    do_cmd(3'b010, 3'd5, 8'h00, lat, e, r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL inc_wrap_mem: got %h want 00", r); end
    do_cmd(3'b001, 3'd6, 8'h41, lat, e, r);
    do_cmd(3'b100, 3'd6, 8'h00, lat, e, r);
    checks++; if (r !== 8'h42) begin errors++; $display("FAIL inc_rdata: got %h want 42", r); end
    do_cmd(3'b010, 3'd6, 8'h00, lat, e, r);
    checks++; if (r !== 8'h42) begin errors++; $display("FAIL inc_mem: got %h want 42", r); end
  endtask

  task automatic test_clear;
    int lat; logic e; logic [7:0] r; logic [7:0] v; int busy;
    for (int i = 0; i < 8; i++) begin
      v = 8'(i * 17 + 1);
      do_cmd(3'b001, 3'(i), v, lat, e, r);
    end
    do_cmd(3'b010, 3'd7, 8'h00, lat, e, r);
    checks++; if (r !== 8'h78) begin errors++; $display("FAIL clr_prefill: got %h want 78", r); end
    send(3'b011, 3'd0, 8'h00);
    busy = 0;
    for (int n = 0; n < 12 && cmd_ready === 1'b0; n++) begin
      busy++;
      @(posedge clk); #1;
    end
    checks++; if (busy != 9) begin errors++; $display("FAIL clr_busy_cycles: got %0d want 9", busy); end
    checks++; if (rdata !== 8'h78) begin errors++; $display("FAIL clr_rdata_kept: got %h want 78", rdata); end
    for (int i = 0; i < 8; i++) begin
      do_cmd(3'b010, 3'(i), 8'h00, lat, e, r);
      checks++; if (r !== 8'h00) begin errors++; $display("FAIL clr_word%0d: got %h want 00", i, r); end
    end
  endtask

  task automatic test_clear_latency;
    int lat; logic e; logic [7:0] r;
    do_cmd(3'b011, 3'd0, 8'h00, lat, e, r);
    checks++; if (lat != 9) begin errors++; $display("FAIL clr_latency: got %0d want 9", lat); end
  endtask

  task automatic test_illegal;
    int lat; logic e; logic [7:0] r;
    do_cmd(3'b001, 3'd1, 8'h5A, lat, e, r);
    do_cmd(3'b010, 3'd1, 8'h00, lat, e, r);
    do_cmd(3'b110, 3'd1, 8'hEE, lat, e, r);
    checks++; if (lat != 1) begin errors++; $display("FAIL ill_latency: got %0d want 1", lat); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL ill_err: got %b want 1", e); end
    checks++; if (r !== 8'h5A) begin errors++; $display("FAIL ill_rdata: got %h want 5a", r); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ill_err_after: got %b want 0", err); end
    do_cmd(3'b010, 3'd1, 8'h00, lat, e, r);
    checks++; if (r !== 8'h5A) begin errors++; $display("FAIL ill_mem_kept: got %h want 5a", r); end
    ms = 3'b000; addr = 3'd1; wdata = 8'h11; cmd_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL nop_done c%0d: got %b want 0", n, done); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL nop_ready c%0d: got %b want 1", n, cmd_ready); end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset_abort;
    int lat; logic e; logic [7:0] r; int seen;
    do_cmd(3'b001, 3'd2, 8'h3C, lat, e, r);
    do_cmd(3'b001, 3'd7, 8'h77, lat, e, r);
    send(3'b011, 3'd0, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", cmd_ready); end
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      if (done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
    do_cmd(3'b010, 3'd2, 8'h00, lat, e, r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL abort_word2: got %h want 00", r); end
    do_cmd(3'b010, 3'd7, 8'h00, lat, e, r);
`ifdef MEMRESP_RESET_CLEAR_EN
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL abort_word7: got %h want 00", r); end
`else
    checks++; if (r !== 8'h77) begin errors++; $display("FAIL abort_word7: got %h want 77", r); end
`endif
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_inc;
    test_clear;
    test_clear_latency;
    test_illegal;
    test_reset_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
